// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : multi-cycle radix-2 multiply/divide/multiply-accumulate engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 is_div_q, is_div_d;
  logic                 is_acc_q, is_acc_d;
  logic                 is_sub_q, is_sub_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic [2*WIDTH-1:0]   out_q, out_d;

  // Operand decode and magnitude conversion at capture time
  logic                 w_signed, w_a_neg, w_b_neg, w_new_div;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;

  assign w_signed  = ~op_i[0];
  assign w_a_neg   = w_signed & opdata1_i[WIDTH-1];
  assign w_b_neg   = w_signed & opdata2_i[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -opdata1_i : opdata1_i;
  assign w_b_mag   = w_b_neg ? -opdata2_i : opdata2_i;
  assign w_new_div = ~op_i[2] & op_i[1];

  // acc_q holds {partial sum, multiplier} for multiply and {remainder, quotient} for divide
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_msum, w_dshift, w_ddiff;
  logic [2*WIDTH-1:0]   w_mstep, w_dstep, w_step, w_fix, w_accres;
  logic [WIDTH-1:0]     w_rem, w_quo;

  assign w_addend = acc_q[0] ? opb_q : '0;
  assign w_msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mstep  = {w_msum, acc_q[WIDTH-1:1]};

  // Partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow
  assign w_dshift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, opb_q};
  assign w_dstep  = {(w_ddiff[WIDTH] ? w_dshift[WIDTH-1:0] : w_ddiff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~w_ddiff[WIDTH]};

  assign w_step   = is_div_q ? w_dstep : w_mstep;
  assign w_rem    = rneg_q ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
  assign w_quo    = neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
  assign w_fix    = is_div_q ? {w_rem, w_quo} : (neg_q ? -w_step : w_step);
  assign w_accres = is_sub_q ? (hilo_q - acc_q) : (hilo_q + acc_q);

  assign busy_o        = (state_q != IDLE);
  assign ready_o       = (state_q == DONE) & ~annul_i;
  assign div_by_zero_o = ready_o & dbz_q;
  assign result_o      = ready_o ? res_q : out_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    is_acc_d = is_acc_q;
    is_sub_d = is_sub_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hilo_d   = hilo_q;
    res_d    = res_q;
    out_d    = ready_o ? res_q : out_q;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          is_div_d = w_new_div;
          is_acc_d = op_i[2];
          is_sub_d = op_i[2] & op_i[1];
          hilo_d   = hilo_i;
          opb_d    = w_new_div ? w_b_mag : w_a_mag;
          acc_d    = {{WIDTH{1'b0}}, (w_new_div ? w_a_mag : w_b_mag)};
          neg_d    = w_a_neg ^ w_b_neg;
          rneg_d   = w_a_neg;
          count_d  = '0;
          dbz_d    = w_new_div && (opdata2_i == '0);
          if (w_new_div && (opdata2_i == '0)) begin
            res_d   = '0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          acc_d   = w_step;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            if (is_acc_q) begin
              acc_d   = w_fix;
              state_d = ACC;
            end else begin
              res_d   = w_fix;
              state_d = DONE;
            end
          end
        end
      end
      ACC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          res_d   = w_accres;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      is_acc_q <= 1'b0;
      is_sub_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      hilo_q   <= '0;
      res_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      is_acc_q <= is_acc_d;
      is_sub_q <= is_sub_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hilo_q   <= hilo_d;
      res_q    <= res_d;
      out_q    <= out_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed scoreboard bench for muldiv_unit (WIDTH=32 and 8)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, annul_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] hilo_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o, div_by_zero_o;

  logic        start8, annul8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] hilo8, result8;
  logic        ready8, busy8, dbz8;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] res;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hilo_i(hilo_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o),
    .div_by_zero_o(div_by_zero_o)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .op_i(op8),
    .opdata1_i(a8), .opdata2_i(b8), .hilo_i(hilo8),
    .result_o(result8), .ready_o(ready8), .busy_o(busy8),
    .div_by_zero_o(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    logic signed [63:0] sa, sbv, q, r;
    logic [63:0]        ps, pu, res;
    logic [31:0]        qu, ru;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ps  = sa * sbv;
    pu  = {32'b0, a} * {32'b0, b};
    res = '0;
    case (op)
      3'd0: res = ps;
      3'd1: res = pu;
      3'd2: begin
        if (b != 32'd0) begin
          q   = sa / sbv;
          r   = sa % sbv;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b != 32'd0) begin
          qu  = a / b;
          ru  = a % b;
          res = {ru, qu};
        end
      end
      3'd4: res = hilo + ps;
      3'd5: res = hilo + pu;
      3'd6: res = hilo - ps;
      default: res = hilo - pu;
    endcase
    return res;
  endfunction

  // Called just after an active edge with the unit idle; start is sampled at the next edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hilo, input bit hold);
    int   lat, exp_lat;
    bit   seen, busy_ok, dz;
    exp_t e;
    dz      = (op[2:1] == 2'b01) && (b == 32'd0);
    exp_lat = dz ? 1 : (op[2] ? 34 : 33);
    sb.push_back('{res: model(op, a, b, hilo), dbz: dz});
    op_i = op; opdata1_i = a; opdata2_i = b; hilo_i = hilo; start_i = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
    op_i = 3'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
    hilo_i = {$urandom, $urandom};
    lat = 1; busy_ok = 1'b1; seen = 1'b0;
    while (lat <= 100) begin
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    check({tag, "_ready_seen"}, 64'(seen), 64'd1);
    e = sb.pop_front();
    if (seen) begin
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_result"}, result_o, e.res);
      check({tag, "_dbz"}, 64'(div_by_zero_o), 64'(e.dbz));
      check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    end
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, {62'd0, ready_o, busy_o}, 64'd0);
  endtask

  initial begin
    bit bad;
    int lat8;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
    opdata1_i = '0; opdata2_i = '0; hilo_i = '0;
    start8 = 1'b0; annul8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; hilo8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset32", {result_o[60:0], ready_o, busy_o, div_by_zero_o}, 64'd0);
    check("reset8", {45'd0, result8, ready8, busy8, dbz8}, 64'd0);
    rst = 1'b0;

    run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 64'd0, 1'b0);
    check("mult_neg_const", result_o, 64'hFFFFFFFF_FFFFFFF1);
    run_op("divu", 3'd3, 32'd100, 32'd7, 64'd0, 1'b0);
    check("divu_const", result_o, 64'h00000002_0000000E);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 64'd0, 1'b0);
    check("div_neg_const", result_o, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 64'd0, 1'b0);
    check("div_ovf_const", result_o, 64'h00000000_80000000);
    run_op("maddu", 3'd5, 32'd3, 32'd4, 64'h10, 1'b0);
    check("maddu_const", result_o, 64'h1C);
    run_op("msub", 3'd6, 32'd3, 32'd4, 64'd0, 1'b0);
    check("msub_const", result_o, 64'hFFFFFFFF_FFFFFFF4);

    // Annul mid-multiply: no pulse, previous result retained
    op_i = 3'd0; opdata1_i = 32'd9; opdata2_i = 32'd9; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    bad = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (ready_o) bad = 1'b1;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check("annul_no_ready", {62'd0, bad, ready_o}, 64'd0);
    check("annul_idle", 64'(busy_o), 64'd0);
    check("annul_result_kept", result_o, 64'hFFFFFFFF_FFFFFFF4);
    run_op("after_annul", 3'd0, 32'd7, 32'hFFFFFFFA, 64'd0, 1'b0);

    // Start together with annul in IDLE is ignored
    op_i = 3'd1; start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    check("annul_start_ignored", 64'(busy_o), 64'd0);

    run_op("div0", 3'd2, 32'd5, 32'd0, 64'd0, 1'b0);
    check("div0_const", result_o, 64'd0);
    run_op("hold_start", 3'd1, 32'hDEADBEEF, 32'h12345678, 64'd0, 1'b1);

    // Reset in the middle of an operation
    op_i = 3'd0; opdata1_i = 32'd11; opdata2_i = 32'd13; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_outputs", {result_o[60:0], ready_o, busy_o, div_by_zero_o}, 64'd0);
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o || busy_o) bad = 1'b1;
    end
    check("midrst_quiet", 64'(bad), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op("rand", i[2:0], $urandom, $urandom, {$urandom, $urandom}, 1'b0);
    end
    run_op("div_negdiv", 3'd2, 32'd7, 32'hFFFFFFFE, 64'd0, 1'b0);
    check("div_negdiv_const", result_o, 64'h00000001_FFFFFFFD);

    // WIDTH=8 instance
    op8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat8 = 1;
    while (lat8 <= 50 && !ready8) begin
      @(posedge clk); #1;
      lat8++;
    end
    check("w8_latency", 64'(lat8), 64'd9);
    check("w8_result", 64'(result8), 64'h0000_FE01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide engine shared by the execute stage; one operation in flight at a time.
- Covers MULT/MULTU, DIV/DIVU and MADD/MADDU/MSUB/MSUBU, including the accumulate step, with a start/ready handshake and annul for flushes.
- Result is a double-width {HI,LO} value for the execute stage to drive onto hi_o/lo_o.

Parameters:
- WIDTH, 32, operand width in bits (even, >=4); result width is 2*WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- annul_i  in  1  cancel the in-flight operation (pipeline flush/exception).
- op_i  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- opdata1_i  in  WIDTH  multiplicand/dividend; captured with start.
- opdata2_i  in  WIDTH  multiplier/divisor; captured with start.
- hilo_i  in  2*WIDTH  current {HI,LO} for accumulate ops; captured with start.
- result_o  out  2*WIDTH  product/accumulated value, or {remainder,quotient} for divides.
- ready_o  out  1  one-cycle pulse; result_o is valid in this cycle.
- busy_o  out  1  high in every state except IDLE.
- div_by_zero_o  out  1  high with ready_o when a divide had opdata2_i==0.

Behaviour:
- Reset (rst=1 at an edge) from any state: state=IDLE, result_o=0, ready_o=0, busy_o=0, div_by_zero_o=0, internal registers cleared.
- States: IDLE, CALC, ACC, DONE.
- IDLE: start_i=1 and annul_i=0 at edge N captures op, operands and hilo_i.
  - Signed ops: operands converted to magnitudes; result sign recorded.
  - Divide with zero divisor: go to DONE.
  - Otherwise: go to CALC with count=0.
- CALC: one radix-2 step per cycle for WIDTH cycles.
  - Multiply: shift-add, 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing one quotient bit per cycle.
  - At count==WIDTH-1: accumulate ops go to ACC; all others go to DONE.
  - Sign fix-up is applied on the CALC->next transition.
- Signed multiply: product negated if the operand signs differ.
- Signed divide: quotient negated if signs differ; remainder takes the dividend's sign.
  - Most-negative / -1 gives quotient = most-negative, remainder 0; no trap.
- ACC: MADD/MADDU gives result = hilo + product; MSUB/MSUBU gives result = hilo - product. Both mod 2^(2*WIDTH), one cycle, then DONE.
- DONE: ready_o=1 for exactly one cycle, then IDLE. The next start_i is accepted no earlier than the DONE->IDLE edge.
- Latency (edge N samples start): ready_o high in cycle N+WIDTH+1 for MULT/DIV; N+WIDTH+2 for MADD/MSUB; N+1 for divide-by-zero.
- Divide-by-zero: result_o=0, div_by_zero_o=1 with ready_o.
- result_o holds its value after DONE until the next result is written; it is not cleared on return to IDLE.
- start_i while busy_o=1 is ignored; operands and op are not re-sampled mid-operation.
- annul_i=1 in CALC/ACC/DONE: next state IDLE, no ready_o pulse, result_o unchanged.
  - annul_i with start_i in IDLE: start is ignored.
  - annul_i wins over completion in the same cycle.
- Operand inputs may change freely after the capture edge.

Test Plan:
- WIDTH=32, MULT -3 (FFFFFFFD) x 5 -> ready_o at N+33, result_o=FFFFFFFF_FFFFFFF1; busy_o high N+1..N+33.
- DIVU 100/7 -> result_o=00000002_0000000E. DIV -7/2 -> result_o=FFFFFFFF_FFFFFFFD. DIV 80000000/FFFFFFFF -> 00000000_80000000.
- MADDU hilo=0x10, 3x4 -> ready_o at N+34, result_o=0x1C. MSUB hilo=0, 3x4 -> FFFFFFFF_FFFFFFF4.
- DIV 5/0 -> ready_o and div_by_zero_o at N+1, result_o=0.
- MULT started, annul_i at N+10 -> IDLE at N+11, no ready_o, result_o retains the prior value; new start at N+11 completes normally.
- Reset mid-operation:
  - rst at N+5 -> all outputs 0, state IDLE, no ready_o.
  - Start held high while busy -> only one ready_o pulse.
- WIDTH=8, MULTU FFxFF -> ready_o at N+9, result_o=FE01.
